// File: rtl/adapt_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eq_ctrl_pkg : state codes, default step sizes and width helpers for the    |
// |               adaptive FFE scheduler.                        Rev 1.0       |
// +----------------------------------------------------------------------------+
package eq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_ACQ   = 3'd2,
    ST_TRK   = 3'd3,
    ST_LMS   = 3'd4
  } state_e;

  localparam logic [15:0] MU_ACQ_DEF = 16'h0400;
  localparam logic [15:0] MU_TRK_DEF = 16'h0080;
  localparam logic [15:0] MU_LMS_DEF = 16'h0040;

  // Sum of 2^log_win magnitudes, each at most 2^(nb_err-1)-1, fits without overflow.
  function automatic int nb_acc(input int nb_err, input int log_win);
    return nb_err + log_win - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adapt_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adapt_scheduler_if : control/status bundle between the scheduler and its   |
// |                      controller.                             Rev 1.0       |
// +----------------------------------------------------------------------------+
interface adapt_scheduler_if #(
  parameter int NB_ERR = 18,
  parameter int NB_MU  = 16,
  parameter int NB_ACC = 27
);
  logic                     i_en;
  logic                     i_valid;
  logic                     i_start;
  logic                     i_freeze;
  logic signed [NB_ERR-1:0] i_err;
  logic                     i_err_valid;
  logic [NB_ACC-1:0]        i_lock_thr;
  logic [NB_ACC-1:0]        i_unlock_thr;
  logic [NB_MU-1:0]         o_mu;
  logic                     o_lms_sel;
  logic                     o_update_en;
  logic                     o_coeff_init;
  logic                     o_locked;
  logic [2:0]               o_state;

  modport master (
    output i_en, i_valid, i_start, i_freeze, i_err, i_err_valid, i_lock_thr, i_unlock_thr,
    input  o_mu, o_lms_sel, o_update_en, o_coeff_init, o_locked, o_state
  );

  modport slave (
    input  i_en, i_valid, i_start, i_freeze, i_err, i_err_valid, i_lock_thr, i_unlock_thr,
    output o_mu, o_lms_sel, o_update_en, o_coeff_init, o_locked, o_state
  );
endinterface
`default_nettype wire

// File: rtl/adapt_scheduler_err_window_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | err_window_acc : sums saturated |err| over 2^LOG_WIN samples; o_done marks  |
// |                  the closing sample, o_sum includes it.      Rev 1.0       |
// +----------------------------------------------------------------------------+
module err_window_acc #(
  parameter int NB_ERR  = 18,
  parameter int LOG_WIN = 10,
  parameter int NB_ACC  = NB_ERR + LOG_WIN - 1
) (
  input  wire logic                     i_clock,
  input  wire logic                     i_reset,
  input  wire logic                     i_clear,
  input  wire logic                     i_sample,
  input  wire logic signed [NB_ERR-1:0] i_err,
  output logic [NB_ACC-1:0]             o_sum,
  output logic                          o_done
);
  localparam logic [NB_ERR-1:0]  ERR_MIN = {1'b1, {(NB_ERR-1){1'b0}}};
  localparam logic [LOG_WIN-1:0] CNT_ONE = LOG_WIN'(1);

  logic [NB_ERR-1:0]  neg_err;
  logic [NB_ERR-2:0]  abs_err;
  logic [NB_ACC-1:0]  acc_q, acc_d;
  logic [LOG_WIN-1:0] cnt_q, cnt_d;

  // The most negative code has no positive twin, so it clamps to full scale.
  always_comb begin
    neg_err = -i_err;
    if (i_err == ERR_MIN)   abs_err = '1;
    else if (i_err[NB_ERR-1]) abs_err = neg_err[NB_ERR-2:0];
    else                    abs_err = i_err[NB_ERR-2:0];
  end

  assign o_sum  = acc_q + {{LOG_WIN{1'b0}}, abs_err};
  assign o_done = i_sample && (cnt_q == '1);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_clear || o_done) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (i_sample) begin
      acc_d = o_sum;
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/adapt_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adapt_scheduler : adaptive FFE schedule (flush, CMA acquire/track, LMS)    |
// |                   driving step size, CMA/LMS select and update strobe. Rev 1.0 |
// +----------------------------------------------------------------------------+
module adapt_scheduler
  import eq_ctrl_pkg::*;
#(
  parameter int               FLUSH_LEN = 21,
  parameter int               ACQ_LEN   = 4096,
  parameter int               UPD_DECIM = 4,
  parameter int               LOG_WIN   = 10,
  parameter int               NB_ERR    = 18,
  parameter int               NB_MU     = 16,
  parameter logic [NB_MU-1:0] MU_ACQ    = NB_MU'(MU_ACQ_DEF),
  parameter logic [NB_MU-1:0] MU_TRK    = NB_MU'(MU_TRK_DEF),
  parameter logic [NB_MU-1:0] MU_LMS    = NB_MU'(MU_LMS_DEF)
) (
  input wire logic         i_clock,
  input wire logic         i_reset,
  adapt_scheduler_if.slave bus
);
  localparam int NB_ACC  = nb_acc(NB_ERR, LOG_WIN);
  localparam int SYM_MAX = (FLUSH_LEN > ACQ_LEN) ? FLUSH_LEN : ACQ_LEN;
  localparam int NB_SYM  = $clog2(SYM_MAX + 1);
  localparam int NB_DEC  = (UPD_DECIM > 1) ? $clog2(UPD_DECIM) : 1;

  localparam logic [NB_SYM-1:0] FLUSH_LAST = NB_SYM'(FLUSH_LEN - 1);
  localparam logic [NB_SYM-1:0] ACQ_LAST   = NB_SYM'(ACQ_LEN - 1);
  localparam logic [NB_SYM-1:0] SYM_ONE    = NB_SYM'(1);
  localparam logic [NB_DEC-1:0] DEC_LAST   = NB_DEC'(UPD_DECIM - 1);
  localparam logic [NB_DEC-1:0] DEC_ONE    = NB_DEC'(1);

  state_e            state_q, state_d;
  logic [NB_SYM-1:0] sym_cnt_q, sym_cnt_d;
  logic [NB_DEC-1:0] dec_cnt_q, dec_cnt_d;
  logic [NB_MU-1:0]  mu_q, mu_d;
  logic              lms_sel_q, lms_sel_d;
  logic              locked_q, locked_d;
  logic              update_en_q, update_en_d;
  logic              coeff_init_q, coeff_init_d;

  logic              tick, start, run_st, win_st, enter, dec_wrap;
  logic              win_done;
  logic [NB_ACC-1:0] win_sum;

  assign tick   = bus.i_valid & bus.i_en;
  assign start  = bus.i_start & bus.i_en;
  assign run_st = (state_q == ST_ACQ) || (state_q == ST_TRK) || (state_q == ST_LMS);
  assign win_st = (state_q == ST_TRK) || (state_q == ST_LMS);

  err_window_acc #(
    .NB_ERR  (NB_ERR),
    .LOG_WIN (LOG_WIN),
    .NB_ACC  (NB_ACC)
  ) u_err_window_acc (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (enter),
    .i_sample (bus.i_err_valid & bus.i_en & win_st),
    .i_err    (bus.i_err),
    .o_sum    (win_sum),
    .o_done   (win_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH: if (tick && sym_cnt_q == FLUSH_LAST) state_d = ST_ACQ;
      ST_ACQ:   if (tick && sym_cnt_q == ACQ_LAST)   state_d = ST_TRK;
      ST_TRK:   if (win_done && win_sum < bus.i_lock_thr)   state_d = ST_LMS;
      ST_LMS:   if (win_done && win_sum > bus.i_unlock_thr) state_d = ST_TRK;
      default:  state_d = state_q;
    endcase
    // Restart overrides whatever the current state would have done.
    if (start) state_d = ST_FLUSH;

    enter     = start || (state_d != state_q);
    dec_wrap  = run_st && tick && (dec_cnt_q == DEC_LAST);

    sym_cnt_d = enter ? '0 : (tick ? sym_cnt_q + SYM_ONE : sym_cnt_q);
    if (enter)                dec_cnt_d = '0;
    else if (dec_wrap)        dec_cnt_d = '0;
    else if (run_st && tick)  dec_cnt_d = dec_cnt_q + DEC_ONE;
    else                      dec_cnt_d = dec_cnt_q;

    update_en_d  = dec_wrap && !bus.i_freeze && !enter;
    coeff_init_d = start;

    case (state_d)
      ST_ACQ:  mu_d = MU_ACQ;
      ST_TRK:  mu_d = MU_TRK;
      ST_LMS:  mu_d = MU_LMS;
      default: mu_d = '0;
    endcase
    lms_sel_d = (state_d == ST_LMS);
    locked_d  = (state_d == ST_LMS);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      dec_cnt_q    <= '0;
      mu_q         <= '0;
      lms_sel_q    <= 1'b0;
      locked_q     <= 1'b0;
      update_en_q  <= 1'b0;
      coeff_init_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      mu_q         <= mu_d;
      lms_sel_q    <= lms_sel_d;
      locked_q     <= locked_d;
      update_en_q  <= update_en_d;
      coeff_init_q <= coeff_init_d;
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_mu         = mu_q;
  assign bus.o_lms_sel    = lms_sel_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_update_en  = update_en_q;
  assign bus.o_coeff_init = coeff_init_q;
endmodule
`default_nettype wire
